mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 5: cycles from request acceptance to memory access (legal range 1..15).
REQ-002 Widths ADDR_SIZE and WD_SIZE SHALL come from PARAMS_pkg.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ic_req_valid  in  1  instruction-side read request.
REQ-006 ic_req_addr  in  ADDR_SIZE  instruction-side read address.
REQ-007 ic_req_ready  out  1  instruction request accepted this cycle.
REQ-008 ic_rsp_valid  out  1  one-cycle pulse; ic_rsp_data valid.
REQ-009 ic_rsp_data  out  WD_SIZE  instruction read data.
REQ-010 dc_req_valid  in  1  data-side request.
REQ-011 dc_req_rd_wr  in  1  0 read, 1 write.
REQ-012 dc_req_addr  in  ADDR_SIZE  data-side address.
REQ-013 dc_req_wr_data / dc_req_wr_keep  in  WD_SIZE each  write data / per-byte keep mask.
REQ-014 dc_req_ready  out  1  data request accepted this cycle.
REQ-015 dc_rsp_valid  out  1  one-cycle pulse; read data valid or write complete.
REQ-016 dc_rsp_data  out  WD_SIZE  data read result (0 for writes).
REQ-017 mem_addr, mem_op_rd_wr, mem_op_en, mem_wr_data, mem_wr_keep  out  ADDR_SIZE,1,1,WD_SIZE,WD_SIZE  drive the shared memory port.
REQ-018 mem_rd_data  in  WD_SIZE  combinational memory read data, valid in the mem_op_en cycle.

Function
REQ-019 FSM states IDLE, WAIT, RESP; IDLE->WAIT on accept, WAIT->RESP when counter reaches 0, RESP->IDLE unconditionally.
REQ-020 Requests SHALL be accepted only in IDLE; at most one of ic_req_ready/dc_req_ready high per cycle, and only when the matching valid is high.
REQ-021 Arbitration: single requester wins; both valid -> round-robin, the side not granted last wins; last-grant pointer updates on every accept.
REQ-022 On accept, requester id, rd_wr (IC forced 0), addr, wr_data, wr_keep SHALL be latched; counter loaded with MEM_LATENCY-1.
REQ-023 In WAIT counter decrements each cycle; mem_op_en=1 exactly in the WAIT cycle where counter==0, with mem_* driven from latched values.
REQ-024 mem_op_en SHALL be 0 in all other cycles; mem_addr/mem_wr_data/mem_wr_keep/mem_op_rd_wr hold latched values otherwise.
REQ-025 Latency: accept at cycle T -> mem_op_en at T+MEM_LATENCY -> rsp_valid at T+MEM_LATENCY+1 (RESP state).
REQ-026 In the mem_op_en cycle mem_rd_data (reads) or 0 (writes) SHALL be registered into the granted side's rsp_data; the other side's rsp_data holds its value.
REQ-027 Only the granted side's rsp_valid pulses, for exactly one cycle.
REQ-028 Requesters hold valid and payload stable until ready; unaccepted requests are never dropped or reordered.
REQ-029 Next accept possible earliest one cycle after RESP; throughput one transaction per MEM_LATENCY+2 cycles.
REQ-030 MEM_LATENCY=1: WAIT lasts one cycle, mem_op_en in the cycle after accept.

Reset
REQ-031 reset_n low SHALL immediately force: state IDLE, counter 0, both ready 0, both rsp_valid 0, both rsp_data 0, mem_op_en 0, all latched fields 0, last-grant pointer = IC (so DC wins first tie).
REQ-032 Reset mid-transaction aborts it: no mem_op_en and no rsp_valid for that transaction; first accept possible in the first cycle after reset_n rises.

Verification
REQ-033 MEM_LATENCY=5, IC read addr 0x10 accepted at T, mem_rd_data=0xDEADBEEF -> mem_op_en only at T+5 with mem_addr=0x10, mem_op_rd_wr=0; ic_rsp_valid at T+6, ic_rsp_data=0xDEADBEEF.
REQ-034 Both valid out of reset -> DC granted first; IC held valid -> granted on next IDLE at T+7; third tie after both -> DC.
REQ-035 DC write addr 0x20, wr_data 0x11223344, wr_keep 0x0000FFFF -> mem_op_en at T+5 with mem_op_rd_wr=1, those values; dc_rsp_valid at T+6, dc_rsp_data=0.
REQ-036 Request valid during WAIT/RESP -> ready stays 0, mem port unaffected; accepted in next IDLE with original payload.
REQ-037 reset_n low at T+3 of a read -> no mem_op_en, no rsp_valid; all outputs at reset values while low.
REQ-038 MEM_LATENCY=1 build: IC read -> mem_op_en at T+1, ic_rsp_valid at T+2; back-to-back IC reads accepted every 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction and data sides share one memory port.
// One transaction is in flight at a time, with a fixed access latency.
package PARAMS_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int WD_SIZE   = 32;
endpackage

module mem_arbiter
  import PARAMS_pkg::*;
#(
  parameter int MEM_LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ic_req_valid,
  input  logic [ADDR_SIZE-1:0] ic_req_addr,
  output logic                 ic_req_ready,
  output logic                 ic_rsp_valid,
  output logic [WD_SIZE-1:0]   ic_rsp_data,
  input  logic                 dc_req_valid,
  input  logic                 dc_req_rd_wr,
  input  logic [ADDR_SIZE-1:0] dc_req_addr,
  input  logic [WD_SIZE-1:0]   dc_req_wr_data,
  input  logic [WD_SIZE-1:0]   dc_req_wr_keep,
  output logic                 dc_req_ready,
  output logic                 dc_rsp_valid,
  output logic [WD_SIZE-1:0]   dc_rsp_data,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_op_rd_wr,
  output logic                 mem_op_en,
  output logic [WD_SIZE-1:0]   mem_wr_data,
  output logic [WD_SIZE-1:0]   mem_wr_keep,
  input  logic [WD_SIZE-1:0]   mem_rd_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic                 r_last_ic;
  logic                 r_id_dc;
  logic                 r_rd_wr;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [WD_SIZE-1:0]   r_wr_data;
  logic [WD_SIZE-1:0]   r_wr_keep;
  logic                 r_ic_rsp_valid;
  logic                 r_dc_rsp_valid;
  logic [WD_SIZE-1:0]   r_ic_rsp_data;
  logic [WD_SIZE-1:0]   r_dc_rsp_data;
  logic                 w_grant_ic;
  logic                 w_grant_dc;
  logic                 w_mem_en;

  // Ready is gated by reset_n so nothing is granted while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_ic  = 1'b0;
    w_grant_dc  = 1'b0;
    w_mem_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (reset_n) begin
          w_grant_dc = dc_req_valid & (~ic_req_valid | r_last_ic);
          w_grant_ic = ic_req_valid & ~w_grant_dc;
        end
        if (w_grant_ic || w_grant_dc) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_mem_en    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 4'd0;
      r_last_ic      <= 1'b1;
      r_id_dc        <= 1'b0;
      r_rd_wr        <= 1'b0;
      r_addr         <= '0;
      r_wr_data      <= '0;
      r_wr_keep      <= '0;
      r_ic_rsp_valid <= 1'b0;
      r_dc_rsp_valid <= 1'b0;
      r_ic_rsp_data  <= '0;
      r_dc_rsp_data  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ic_rsp_valid <= w_mem_en & ~r_id_dc;
      r_dc_rsp_valid <= w_mem_en & r_id_dc;
      if (w_grant_ic || w_grant_dc) begin
        r_id_dc   <= w_grant_dc;
        r_last_ic <= w_grant_ic;
        r_rd_wr   <= w_grant_dc & dc_req_rd_wr;
        r_addr    <= w_grant_dc ? dc_req_addr : ic_req_addr;
        r_wr_data <= w_grant_dc ? dc_req_wr_data : '0;
        r_wr_keep <= w_grant_dc ? dc_req_wr_keep : '0;
        r_cnt     <= CNT_LOAD;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_mem_en) begin
        if (r_id_dc) r_dc_rsp_data <= r_rd_wr ? '0 : mem_rd_data;
        else         r_ic_rsp_data <= mem_rd_data;
      end
    end
  end

  assign ic_req_ready = w_grant_ic;
  assign dc_req_ready = w_grant_dc;
  assign ic_rsp_valid = r_ic_rsp_valid;
  assign dc_rsp_valid = r_dc_rsp_valid;
  assign ic_rsp_data  = r_ic_rsp_data;
  assign dc_rsp_data  = r_dc_rsp_data;
  assign mem_op_en    = w_mem_en;
  assign mem_addr     = r_addr;
  assign mem_op_rd_wr = r_rd_wr;
  assign mem_wr_data  = r_wr_data;
  assign mem_wr_keep  = r_wr_keep;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a timestamp model.
// A second instance built with MEM_LATENCY=1 covers the shortest-latency configuration.
module tb_mem_arbiter;
  import PARAMS_pkg::*;

  localparam int L = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic        ic_v = 0, dc_v = 0, dc_rw = 0;
  logic [31:0] ic_a = 0, dc_a = 0, dc_wd = 0, dc_wk = 0, m_rd = 0;
  logic        ic_rdy, ic_rv, dc_rdy, dc_rv, m_rw, m_en;
  logic [31:0] ic_rd, dc_rd, m_a, m_wd, m_wk;

  logic        l1_ic_v = 0;
  logic [31:0] l1_ic_a = 0, l1_m_rd = 0;
  logic        l1_ic_rdy, l1_ic_rv, l1_dc_rdy, l1_dc_rv, l1_m_rw, l1_m_en;
  logic [31:0] l1_ic_rd, l1_dc_rd, l1_m_a, l1_m_wd, l1_m_wk;

  mem_arbiter #(.MEM_LATENCY(L)) u5 (
    .clk(clk), .reset_n(reset_n),
    .ic_req_valid(ic_v), .ic_req_addr(ic_a), .ic_req_ready(ic_rdy),
    .ic_rsp_valid(ic_rv), .ic_rsp_data(ic_rd),
    .dc_req_valid(dc_v), .dc_req_rd_wr(dc_rw), .dc_req_addr(dc_a),
    .dc_req_wr_data(dc_wd), .dc_req_wr_keep(dc_wk), .dc_req_ready(dc_rdy),
    .dc_rsp_valid(dc_rv), .dc_rsp_data(dc_rd),
    .mem_addr(m_a), .mem_op_rd_wr(m_rw), .mem_op_en(m_en),
    .mem_wr_data(m_wd), .mem_wr_keep(m_wk), .mem_rd_data(m_rd)
  );

  mem_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .ic_req_valid(l1_ic_v), .ic_req_addr(l1_ic_a), .ic_req_ready(l1_ic_rdy),
    .ic_rsp_valid(l1_ic_rv), .ic_rsp_data(l1_ic_rd),
    .dc_req_valid(1'b0), .dc_req_rd_wr(1'b0), .dc_req_addr(32'h0),
    .dc_req_wr_data(32'h0), .dc_req_wr_keep(32'h0), .dc_req_ready(l1_dc_rdy),
    .dc_rsp_valid(l1_dc_rv), .dc_rsp_data(l1_dc_rd),
    .mem_addr(l1_m_a), .mem_op_rd_wr(l1_m_rw), .mem_op_en(l1_m_en),
    .mem_wr_data(l1_m_wd), .mem_wr_keep(l1_m_wk), .mem_rd_data(l1_m_rd)
  );

  task automatic apply_reset();
    reset_n = 1'b0;
    ic_v = 0; dc_v = 0; l1_ic_v = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ic_v = 1; dc_v = 1; l1_ic_v = 1;
    @(negedge clk);
    if ({ic_rdy, dc_rdy, l1_ic_rdy} !== 3'b000) begin n_err++; $display("FAIL reset ready got %b exp 000", {ic_rdy, dc_rdy, l1_ic_rdy}); end
    n_chk++;
    if ({ic_rv, dc_rv, m_en, m_rw} !== 4'b0000) begin n_err++; $display("FAIL reset ctl got %b exp 0000", {ic_rv, dc_rv, m_en, m_rw}); end
    n_chk++;
    if ({ic_rd, dc_rd, m_a, m_wd, m_wk} !== 160'h0) begin n_err++; $display("FAIL reset data got %h exp 0", {ic_rd, dc_rd, m_a, m_wd, m_wk}); end
    n_chk++;
    apply_reset();
  endtask

  task automatic test_ic_read();
    @(posedge clk); #1;
    ic_v = 1; ic_a = 32'h10; m_rd = 32'hDEADBEEF;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (ic_rdy !== (k == 0)) begin n_err++; $display("FAIL ic_read k=%0d ready got %b exp %b", k, ic_rdy, k == 0); end
      n_chk++;
      if (m_en !== (k == L)) begin n_err++; $display("FAIL ic_read k=%0d mem_op_en got %b exp %b", k, m_en, k == L); end
      n_chk++;
      if (k == L && (m_a !== 32'h10 || m_rw !== 1'b0)) begin n_err++; $display("FAIL ic_read mem_addr/rd_wr got %h/%b exp 10/0", m_a, m_rw); end
      if (k == L) n_chk++;
      if (ic_rv !== (k == L + 1) || dc_rv !== 1'b0) begin n_err++; $display("FAIL ic_read k=%0d rsp_valid ic/dc got %b/%b", k, ic_rv, dc_rv); end
      n_chk++;
      if (k == L + 1 && ic_rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL ic_read rsp_data got %h exp deadbeef", ic_rd); end
      if (k == L + 1) n_chk++;
      @(posedge clk); #1;
      if (k == 0) ic_v = 0;
    end
  endtask

  task automatic test_tie();
    ic_v = 1; ic_a = 32'h30;
    dc_v = 1; dc_rw = 0; dc_a = 32'h40;
    m_rd = 32'h5555AAAA;
    for (int k = 0; k < 29; k++) begin
      @(negedge clk);
      if (dc_rdy !== (k == 0 || k == 14)) begin n_err++; $display("FAIL tie k=%0d dc_ready got %b", k, dc_rdy); end
      n_chk++;
      if (ic_rdy !== (k == 7 || k == 21)) begin n_err++; $display("FAIL tie k=%0d ic_ready got %b", k, ic_rdy); end
      n_chk++;
      if (m_en !== (k == 5 || k == 12 || k == 19 || k == 26)) begin n_err++; $display("FAIL tie k=%0d mem_op_en got %b", k, m_en); end
      n_chk++;
      if (dc_rv !== (k == 6 || k == 20) || ic_rv !== (k == 13 || k == 27)) begin n_err++; $display("FAIL tie k=%0d rsp_valid ic/dc got %b/%b", k, ic_rv, dc_rv); end
      n_chk++;
      if (k == 5 && m_a !== 32'h40) begin n_err++; $display("FAIL tie mem_addr k=5 got %h exp 40", m_a); end
      if (k == 12 && m_a !== 32'h30) begin n_err++; $display("FAIL tie mem_addr k=12 got %h exp 30", m_a); end
      if (k == 19 && m_a !== 32'h48) begin n_err++; $display("FAIL tie mem_addr k=19 got %h exp 48", m_a); end
      if (k == 26 && m_a !== 32'h34) begin n_err++; $display("FAIL tie mem_addr k=26 got %h exp 34", m_a); end
      if (k == 5 || k == 12 || k == 19 || k == 26) n_chk++;
      @(posedge clk); #1;
      if (k == 0)  dc_v = 0;
      if (k == 7)  ic_v = 0;
      if (k == 8) begin dc_v = 1; dc_a = 32'h48; ic_v = 1; ic_a = 32'h34; end
      if (k == 14) dc_v = 0;
      if (k == 21) ic_v = 0;
    end
  endtask

  task automatic test_dc_write();
    dc_v = 1; dc_rw = 1; dc_a = 32'h20; dc_wd = 32'h11223344; dc_wk = 32'h0000FFFF;
    m_rd = 32'h99999999;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (dc_rdy !== (k == 0) || ic_rdy !== 1'b0) begin n_err++; $display("FAIL dc_write k=%0d ready ic/dc got %b/%b", k, ic_rdy, dc_rdy); end
      n_chk++;
      if (m_en !== (k == L)) begin n_err++; $display("FAIL dc_write k=%0d mem_op_en got %b", k, m_en); end
      n_chk++;
      if (k == L && {m_rw, m_a, m_wd, m_wk} !== {1'b1, 32'h20, 32'h11223344, 32'h0000FFFF}) begin
        n_err++; $display("FAIL dc_write mem port got %b %h %h %h exp 1 20 11223344 0000ffff", m_rw, m_a, m_wd, m_wk);
      end
      if (k == L) n_chk++;
      if (dc_rv !== (k == L + 1) || ic_rv !== 1'b0) begin n_err++; $display("FAIL dc_write k=%0d rsp_valid ic/dc got %b/%b", k, ic_rv, dc_rv); end
      n_chk++;
      if (k == L + 1 && dc_rd !== 32'h0) begin n_err++; $display("FAIL dc_write rsp_data got %h exp 0", dc_rd); end
      if (k == L + 1) n_chk++;
      if (ic_rd !== 32'h5555AAAA) begin n_err++; $display("FAIL dc_write k=%0d ic_rsp_data hold got %h exp 5555aaaa", k, ic_rd); end
      n_chk++;
      @(posedge clk); #1;
      if (k == 0) begin dc_v = 0; dc_rw = 0; end
    end
  endtask

  task automatic test_reset_mid();
    ic_v = 1; ic_a = 32'h44; dc_v = 0; m_rd = 32'hCAFEF00D;
    for (int k = 0; k < 14; k++) begin
      if (k == 3) reset_n = 1'b0;
      if (k == 6) reset_n = 1'b1;
      @(negedge clk);
      if (ic_rdy !== (k == 0 || k == 6)) begin n_err++; $display("FAIL reset_mid k=%0d ic_ready got %b", k, ic_rdy); end
      n_chk++;
      if (m_en !== (k == 11)) begin n_err++; $display("FAIL reset_mid k=%0d mem_op_en got %b", k, m_en); end
      n_chk++;
      if (ic_rv !== (k == 12) || dc_rv !== 1'b0) begin n_err++; $display("FAIL reset_mid k=%0d rsp_valid ic/dc got %b/%b", k, ic_rv, dc_rv); end
      n_chk++;
      if (k >= 3 && k <= 5 && {ic_rd, dc_rd, m_a, m_wd, m_wk, m_rw} !== 161'h0) begin
        n_err++; $display("FAIL reset_mid k=%0d outputs not at reset values: %h %h %h %b", k, ic_rd, dc_rd, m_a, m_rw);
      end
      if (k >= 3 && k <= 5) n_chk++;
      if (k == 12 && ic_rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL reset_mid rsp_data got %h exp cafef00d", ic_rd); end
      if (k == 12) n_chk++;
      @(posedge clk); #1;
      if (k == 6) ic_v = 0;
    end
  endtask

  task automatic test_random();
    int next_free = 0, t_mem = -10;
    bit last_ic = 1, have = 0, t_dc = 0, t_rw = 0, e_ir, e_dr, e_en;
    logic [31:0] t_addr = 0, t_wd = 0, t_wk = 0, e_icd = 0, e_dcd = 0;
    apply_reset();
    ic_v = 1'($urandom_range(0, 1)); ic_a = $urandom;
    dc_v = 1'($urandom_range(0, 1)); dc_rw = 1'($urandom_range(0, 1));
    dc_a = $urandom; dc_wd = $urandom; dc_wk = $urandom; m_rd = $urandom;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      e_ir = 0; e_dr = 0;
      if (cyc >= next_free) begin
        if (dc_v && (!ic_v || last_ic)) e_dr = 1;
        else if (ic_v) e_ir = 1;
      end
      if (ic_rdy !== e_ir || dc_rdy !== e_dr) begin n_err++; $display("FAIL random c=%0d ready ic/dc got %b/%b exp %b/%b", cyc, ic_rdy, dc_rdy, e_ir, e_dr); end
      n_chk++;
      e_en = have && cyc == t_mem;
      if (m_en !== e_en) begin n_err++; $display("FAIL random c=%0d mem_op_en got %b exp %b", cyc, m_en, e_en); end
      n_chk++;
      if (have && (m_a !== t_addr || m_rw !== t_rw)) begin n_err++; $display("FAIL random c=%0d mem_addr/rd_wr got %h/%b exp %h/%b", cyc, m_a, m_rw, t_addr, t_rw); end
      if (have) n_chk++;
      if (e_en && t_rw && (m_wd !== t_wd || m_wk !== t_wk)) begin n_err++; $display("FAIL random c=%0d wr data/keep got %h/%h exp %h/%h", cyc, m_wd, m_wk, t_wd, t_wk); end
      if (e_en && t_rw) n_chk++;
      if (ic_rv !== (have && cyc == t_mem + 1 && !t_dc) || dc_rv !== (have && cyc == t_mem + 1 && t_dc)) begin
        n_err++; $display("FAIL random c=%0d rsp_valid ic/dc got %b/%b", cyc, ic_rv, dc_rv);
      end
      n_chk++;
      if (ic_rd !== e_icd || dc_rd !== e_dcd) begin n_err++; $display("FAIL random c=%0d rsp_data ic/dc got %h/%h exp %h/%h", cyc, ic_rd, dc_rd, e_icd, e_dcd); end
      n_chk++;
      if (e_en) begin
        if (t_dc) e_dcd = t_rw ? 32'h0 : m_rd;
        else      e_icd = m_rd;
      end
      if (e_ir || e_dr) begin
        have = 1; t_dc = e_dr; t_rw = e_dr && dc_rw;
        t_addr = e_dr ? dc_a : ic_a; t_wd = dc_wd; t_wk = dc_wk;
        t_mem = cyc + L; next_free = cyc + L + 2; last_ic = e_ir;
      end
      @(posedge clk); #1;
      if (e_ir || !ic_v) begin ic_v = ($urandom_range(0, 2) != 0); ic_a = $urandom; end
      if (e_dr || !dc_v) begin
        dc_v = ($urandom_range(0, 2) != 0); dc_rw = 1'($urandom_range(0, 1));
        dc_a = $urandom; dc_wd = $urandom; dc_wk = $urandom;
      end
      m_rd = $urandom;
    end
    ic_v = 0; dc_v = 0;
  endtask

  task automatic test_latency1();
    @(posedge clk); #1;
    l1_ic_v = 1; l1_ic_a = 32'h100; l1_m_rd = 32'hA0000000;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (l1_ic_rdy !== (k % 3 == 0)) begin n_err++; $display("FAIL lat1 k=%0d ready got %b", k, l1_ic_rdy); end
      n_chk++;
      if (l1_m_en !== (k % 3 == 1)) begin n_err++; $display("FAIL lat1 k=%0d mem_op_en got %b", k, l1_m_en); end
      n_chk++;
      if (k % 3 == 1 && l1_m_a !== 32'h100 + 32'(4 * (k / 3))) begin n_err++; $display("FAIL lat1 k=%0d mem_addr got %h", k, l1_m_a); end
      if (k % 3 == 1) n_chk++;
      if (l1_ic_rv !== (k % 3 == 2)) begin n_err++; $display("FAIL lat1 k=%0d rsp_valid got %b", k, l1_ic_rv); end
      n_chk++;
      if (k % 3 == 2 && l1_ic_rd !== 32'hA0000000 + 32'(k - 1)) begin n_err++; $display("FAIL lat1 k=%0d rsp_data got %h", k, l1_ic_rd); end
      if (k % 3 == 2) n_chk++;
      @(posedge clk); #1;
      if (k % 3 == 0) l1_ic_a = 32'h100 + 32'(4 * (k / 3 + 1));
      l1_m_rd = 32'hA0000000 + 32'(k + 1);
    end
    l1_ic_v = 0;
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_tie();
    test_dc_write();
    test_reset_mid();
    test_random();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
